// File: rtl/jt10_bus_pkg.sv
// Shared types and constants for the YM2610 CPU-bus writer (jt10_bus_writer, jt10_bus_fifo).

package jt10_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAstb,
    StAwait,
    StDstb,
    StDwait,
    StPgap,
    StPoll
  } state_e;

  typedef struct packed {
    logic       bank;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } req_t;

  localparam int unsigned ReqW       = 17;
  localparam logic        PortAddr   = 1'b0;
  localparam logic        PortData   = 1'b1;
  localparam logic [1:0]  PortStatus = 2'b00;
  localparam int unsigned BusyBit    = 7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jt10_bus_fifo.sv
// Synchronous request FIFO with registered full/empty flags and an occupancy output.

module jt10_bus_fifo
  import jt10_bus_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [ReqW-1:0] i_wdata,
  output logic [ReqW-1:0] o_rdata,
  output logic            o_full,
  output logic            o_empty,
  output logic [AW:0]     o_level
);

  localparam int unsigned Depth   = 1 << AW;
  localparam logic [AW:0] LvlLast = Depth[AW:0] - 1'b1;
  localparam logic [AW:0] LvlOne  = {{AW{1'b0}}, 1'b1};

  logic [ReqW-1:0] r_mem [Depth];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_level;
  logic            r_full, r_empty;
  logic            w_push, w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10: begin
          r_level <= r_level + 1'b1;
          r_empty <= 1'b0;
          r_full  <= (r_level == LvlLast);
        end
        2'b01: begin
          r_level <= r_level - 1'b1;
          r_full  <= 1'b0;
          r_empty <= (r_level == LvlOne);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/jt10_bus_writer.sv
// YM2610 CPU-bus master: replays queued {bank, reg, data} writes as address/data strobe pairs.
// Optional JT10_BUSY_POLL_EN replaces the fixed post-data wait with status-register polling.

module jt10_bus_writer
  import jt10_bus_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned ADDR_WAIT = 17,
  parameter int unsigned DATA_WAIT = 83,
  parameter int unsigned POLL_MAX  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_bank,
  input  logic [7:0]       req_reg,
  input  logic [7:0]       req_data,
  output logic [7:0]       ym_din,
  output logic [1:0]       ym_addr,
  output logic             ym_cs_n,
  output logic             ym_wr_n,
  input  logic [7:0]       ym_dout,
  output logic             idle,
  output logic [FIFO_AW:0] fifo_level,
  output logic             poll_timeout
);

  localparam int unsigned    CntMax = max3(ADDR_WAIT, DATA_WAIT, 1);
  localparam int unsigned    CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] AwLast = CntW'((ADDR_WAIT == 0) ? 0 : ADDR_WAIT - 1);
  localparam logic [CntW-1:0] DwLast = CntW'((DATA_WAIT == 0) ? 0 : DATA_WAIT - 1);

  logic            w_full, w_empty, w_push, w_pop;
  logic [ReqW-1:0] w_head_bits;
  req_t            w_head;
  req_t            r_req;
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_cs_n, r_wr_n;
  logic [1:0]      r_addr;
  logic [7:0]      r_din;

`ifdef JT10_BUSY_POLL_EN
  localparam int unsigned     PollW    = $clog2(max3(POLL_MAX, 1, 1) + 1);
  localparam logic [PollW-1:0] PollLast = PollW'((POLL_MAX == 0) ? 0 : POLL_MAX - 1);
  logic [PollW-1:0] r_poll;
  logic             r_timeout;
  assign poll_timeout = r_timeout;
`else
  logic [7:0] w_unused_poll;
  assign w_unused_poll = ym_dout ^ 8'(POLL_MAX);
  assign poll_timeout  = 1'b0;
`endif

  assign w_head = req_t'(w_head_bits);
  assign w_push = req_valid && !w_full;
  assign w_pop  = cen && (r_state == StIdle) && !w_empty;

  jt10_bus_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata({req_bank, req_reg, req_data}),
    .o_rdata(w_head_bits),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(fifo_level)
  );

  // Strobe outputs are registered and change only on cen ticks, so each strobe spans
  // exactly one cen period. With ADDR_WAIT=0 the two strobes occupy adjacent periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_req   <= '0;
      r_cnt   <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_addr  <= '0;
      r_din   <= '0;
`ifdef JT10_BUSY_POLL_EN
      r_poll    <= '0;
      r_timeout <= 1'b0;
`endif
    end else if (cen) begin
      case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_req   <= w_head;
            r_cs_n  <= 1'b0;
            r_wr_n  <= 1'b0;
            r_addr  <= {w_head.bank, PortAddr};
            r_din   <= w_head.reg_addr;
            r_state <= StAstb;
          end
        end
        StAstb: begin
          r_cnt <= '0;
          if (ADDR_WAIT == 0) begin
            r_addr  <= {r_req.bank, PortData};
            r_din   <= r_req.data;
            r_state <= StDstb;
          end else begin
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_state <= StAwait;
          end
        end
        StAwait: begin
          if (r_cnt == AwLast) begin
            r_cs_n  <= 1'b0;
            r_wr_n  <= 1'b0;
            r_addr  <= {r_req.bank, PortData};
            r_din   <= r_req.data;
            r_state <= StDstb;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDstb: begin
          r_cs_n <= 1'b1;
          r_wr_n <= 1'b1;
          r_cnt  <= '0;
`ifdef JT10_BUSY_POLL_EN
          r_poll  <= '0;
          r_state <= StPgap;
`else
          r_state <= (DATA_WAIT == 0) ? StIdle : StDwait;
`endif
        end
        StDwait: begin
          if (r_cnt == DwLast) begin
            r_state <= StIdle;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef JT10_BUSY_POLL_EN
        StPgap: begin
          r_cs_n  <= 1'b0;
          r_wr_n  <= 1'b1;
          r_addr  <= PortStatus;
          r_state <= StPoll;
        end
        StPoll: begin
          r_cs_n <= 1'b1;
          if (r_poll != '1) r_poll <= r_poll + 1'b1;
          if (!ym_dout[BusyBit]) begin
            r_state <= StIdle;
          end else if (r_poll == PollLast) begin
            r_timeout <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_state <= StPgap;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = !w_full;
  assign idle      = (r_state == StIdle) && w_empty;
  assign ym_cs_n   = r_cs_n;
  assign ym_wr_n   = r_wr_n;
  assign ym_addr   = r_addr;
  assign ym_din    = r_din;

endmodule

// File: tb/tb_jt10_bus_writer.sv
// Directed bench for jt10_bus_writer: vector table of single requests plus FIFO-full,
// slow-cen, async-reset and (with JT10_BUSY_POLL_EN) busy-poll sequences.

module tb_jt10_bus_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_bank = 1'b0;
  logic [7:0] req_reg = '0;
  logic [7:0] req_data = '0;
  logic [7:0] ym_dout = '0;
  logic       req_ready, ym_cs_n, ym_wr_n, idle, poll_timeout;
  logic [7:0] ym_din;
  logic [1:0] ym_addr;
  logic [4:0] fifo_level;

  jt10_bus_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bank    (req_bank),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .ym_din      (ym_din),
    .ym_addr     (ym_addr),
    .ym_cs_n     (ym_cs_n),
    .ym_wr_n     (ym_wr_n),
    .ym_dout     (ym_dout),
    .idle        (idle),
    .fifo_level  (fifo_level),
    .poll_timeout(poll_timeout)
  );

`ifdef JT10_BUSY_POLL_EN
  localparam int PerReq = 3;
`else
  localparam int PerReq = 2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // cen_div=0 holds cen low; otherwise cen is high one clk in every cen_div.
  int cen_div = 1;
  int ph = 0;
  always @(negedge clk) begin
    if (cen_div == 0) cen = 1'b0;
    else begin
      ph  = (ph + 1) % cen_div;
      cen = (ph == 0);
    end
  end

  typedef struct {
    int         fall;
    int         rise;
    logic [1:0] addr;
    logic [7:0] din;
    logic       wr;
  } strobe_t;

  strobe_t log_q[$];
  strobe_t cur;
  logic    prev_cs = 1'b1;
  logic    prev_idle = 1'b1;
  int      idle_rises = 0;
  int      idle_cyc = 0;
  int      reads = 0;
  int      busy_reads = 0;

  // Bus monitor and status-register model: reads 1..busy_reads return busy.
  always @(negedge clk) begin
    if (prev_cs && !ym_cs_n) begin
      cur.fall = cyc;
      cur.addr = ym_addr;
      cur.din  = ym_din;
      cur.wr   = !ym_wr_n;
      if (ym_wr_n) begin
        reads++;
        ym_dout = (reads <= busy_reads) ? 8'h80 : 8'h00;
      end
    end
    if (!prev_cs && ym_cs_n) begin
      cur.rise = cyc;
      log_q.push_back(cur);
    end
    if (!prev_idle && idle) begin
      idle_rises++;
      idle_cyc = cyc;
    end
    prev_cs   = ym_cs_n;
    prev_idle = idle;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic [7:0] r, input logic [7:0] d);
    req_bank  = b;
    req_reg   = r;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      step();
      n++;
    end
    chk("idle_reached", int'(idle), 1);
  endtask

  typedef struct {
    logic       bank;
    logic [7:0] r;
    logic [7:0] d;
    int         a0;
    int         a1;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{1'b0, 8'h28, 8'hF0, 0, 1};
    vt[1] = '{1'b1, 8'h10, 8'h55, 2, 3};
    vt[2] = '{1'b0, 8'hFF, 8'h00, 0, 1};
    vt[3] = '{1'b1, 8'hA5, 8'h3C, 2, 3};

    repeat (3) step();
    chk("rst_cs_n", int'(ym_cs_n), 1);
    chk("rst_wr_n", int'(ym_wr_n), 1);
    chk("rst_din", int'(ym_din), 0);
    chk("rst_addr", int'(ym_addr), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_timeout", int'(poll_timeout), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single requests, cen every clk.
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      push(vt[i].bank, vt[i].r, vt[i].d);
      wait_idle(500);
      chk($sformatf("v%0d_count", i), log_q.size(), PerReq);
      if (log_q.size() >= 2) begin
        chk($sformatf("v%0d_a_addr", i), int'(log_q[0].addr), vt[i].a0);
        chk($sformatf("v%0d_a_din", i), int'(log_q[0].din), int'(vt[i].r));
        chk($sformatf("v%0d_a_wr", i), int'(log_q[0].wr), 1);
        chk($sformatf("v%0d_a_width", i), log_q[0].rise - log_q[0].fall, 1);
        chk($sformatf("v%0d_d_addr", i), int'(log_q[1].addr), vt[i].a1);
        chk($sformatf("v%0d_d_din", i), int'(log_q[1].din), int'(vt[i].d));
        chk($sformatf("v%0d_d_width", i), log_q[1].rise - log_q[1].fall, 1);
        chk($sformatf("v%0d_awgap", i), log_q[1].fall - log_q[0].rise, 17);
`ifndef JT10_BUSY_POLL_EN
        chk($sformatf("v%0d_dwait", i), idle_cyc - log_q[1].rise, 83);
`endif
      end
    end

    // Fill the FIFO with cen frozen; the 17th request must be refused.
    cen_div = 0;
    repeat (2) step();
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("full_ready%0d", i), int'(req_ready), (i < 16) ? 1 : 0);
      push(i[0], 8'h20 + 8'(i), 8'hA0 + 8'(i));
    end
    step();
    chk("full_level", int'(fifo_level), 16);
    chk("full_ready_end", int'(req_ready), 0);
    begin
      int rises0;
      rises0 = idle_rises;
      log_q.delete();
      cen_div = 1;
      wait_idle(4000);
      chk("full_idle_rises", idle_rises - rises0, 1);
      chk("full_count", log_q.size(), 16 * PerReq);
      if (log_q.size() == 16 * PerReq) begin
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("full_reg%0d", i), int'(log_q[i * PerReq].din), 32 + i);
          chk($sformatf("full_dat%0d", i), int'(log_q[i * PerReq + 1].din), 160 + i);
          chk($sformatf("full_bank%0d", i), int'(log_q[i * PerReq].addr), 2 * (i % 2));
        end
`ifndef JT10_BUSY_POLL_EN
        chk("b2b_gap", log_q[2].fall - log_q[1].rise, 84);
        chk("full_last_dwait", idle_cyc - log_q[31].rise, 83);
`endif
      end
    end

    // cen every 4th clk: all timing scales by 4.
    cen_div = 4;
    log_q.delete();
    push(1'b0, 8'h28, 8'hF0);
    wait_idle(3000);
    chk("slow_count", log_q.size(), PerReq);
    if (log_q.size() >= 2) begin
      chk("slow_a_width", log_q[0].rise - log_q[0].fall, 4);
      chk("slow_d_width", log_q[1].rise - log_q[1].fall, 4);
      chk("slow_awgap", log_q[1].fall - log_q[0].rise, 68);
`ifndef JT10_BUSY_POLL_EN
      chk("slow_dwait", idle_cyc - log_q[1].rise, 332);
`endif
    end
    cen_div = 1;
    repeat (8) step();

    // Asynchronous reset during the data strobe flushes the queue.
    push(1'b0, 8'h33, 8'h44);
    push(1'b1, 8'h66, 8'h77);
    begin
      int n = 0;
      while (!(!ym_cs_n && ym_addr == 2'd1) && n < 300) begin
        step();
        n++;
      end
      chk("rst_dstb_seen", int'(!ym_cs_n && ym_addr == 2'd1), 1);
      chk("rst_dstb_level", int'(fifo_level), 1);
    end
    rst_n = 1'b0;
    #1;
    chk("async_cs_n", int'(ym_cs_n), 1);
    chk("async_wr_n", int'(ym_wr_n), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_level", int'(fifo_level), 0);
    chk("post_rst_idle", int'(idle), 1);
    chk("post_rst_ready", int'(req_ready), 1);
    log_q.delete();
    repeat (20) step();
    chk("post_rst_quiet", log_q.size(), 0);

`ifdef JT10_BUSY_POLL_EN
    busy_reads = 3;
    reads = 0;
    push(1'b0, 8'h28, 8'h01);
    wait_idle(500);
    chk("poll_reads", reads, 4);
    chk("poll_no_timeout", int'(poll_timeout), 0);
    busy_reads = 100000;
    reads = 0;
    push(1'b0, 8'h28, 8'h02);
    wait_idle(3000);
    chk("poll_max_reads", reads, 255);
    chk("poll_timeout", int'(poll_timeout), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt10_bus_writer.md
Name: jt10_bus_writer

Overview:
- Bus master that drives the YM2610 CPU-side interface (din, addr, cs_n, wr_n, dout) from a queue of register-write requests.
- Accepts {bank, reg, value} requests over a valid/ready handshake and buffers them in a FIFO.
- Replays each request as an address-write cycle followed by a data-write cycle, with the chip's post-write wait times enforced.
- Sits between a soft-CPU or test sequencer and the YM2610 core, so that no caller ever writes while the chip is busy.

Parameters:
FIFO_AW, 4, log2 of FIFO depth (16 entries of 17 bits each)
ADDR_WAIT, 17, cen ticks to wait after the address strobe before the data strobe; 0 is legal
DATA_WAIT, 83, cen ticks to wait after the data strobe before the next request
POLL_MAX, 255, maximum number of status reads per request (used only with JT10_BUSY_POLL_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
cen  in  1  clock enable shared with the YM2610 core; all bus timing counts cen ticks
req_valid  in  1  request present
req_ready  out  1  FIFO not full
req_bank  in  1  0 selects ports 0/1, 1 selects ports 2/3
req_reg  in  8  register address
req_data  in  8  register value
ym_din  out  8  data to the chip
ym_addr  out  2  port select to the chip
ym_cs_n  out  1  chip select
ym_wr_n  out  1  write strobe
ym_dout  in  8  chip status; bit 7 is busy
idle  out  1  FIFO empty and FSM in IDLE
fifo_level  out  FIFO_AW+1  current FIFO occupancy
poll_timeout  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low) values:
  - ym_cs_n=1, ym_wr_n=1, ym_din=0, ym_addr=0
  - FIFO flushed, fifo_level=0, idle=1, poll_timeout=0, FSM in IDLE
  - Reset asserted mid-cycle releases cs_n/wr_n immediately (asynchronously); the pending request is lost.
- FIFO push: on clk when req_valid && req_ready.
- req_ready = !full, taken from registered state. When the FIFO is full, a pop in the same cycle does not allow a push in that cycle.
- FSM states, all transitions on cen ticks:
  - IDLE → ASTB when the FIFO is non-empty. The head entry is popped into a holding register.
  - ASTB: drive ym_addr={bank,0}, ym_din=reg, cs_n=0, wr_n=0 for exactly one cen period (asserted at one tick, released at the next). Then go to AWAIT.
  - AWAIT: count ADDR_WAIT ticks, then go to DSTB. If ADDR_WAIT=0, go to DSTB directly.
  - DSTB: drive ym_addr={bank,1}, ym_din=data, cs_n=0, wr_n=0 for one cen period. Then go to DWAIT.
  - DWAIT: count DATA_WAIT ticks, then go to IDLE.
- Back-to-back requests: IDLE lasts one cen tick. The next ASTB begins on the following tick.
- While cs_n=1, ym_addr and ym_din hold their last values.
- The wait counter is sized for max(ADDR_WAIT, DATA_WAIT, 1) and saturates; it never wraps.
- cen held low freezes the FSM and counters. The FIFO still accepts pushes.

Optional Feature:
- Macro: JT10_BUSY_POLL_EN.
- Defined: DWAIT is replaced by POLL.
  - After the data strobe, wait one idle cen tick, then issue a read: ym_addr=0, cs_n=0, wr_n=1 for one cen period.
  - Sample ym_dout[7] on the closing tick. If 0, go to IDLE; if 1, repeat the read.
  - After POLL_MAX reads that all return busy, set poll_timeout and go to IDLE.
- Undefined: fixed DATA_WAIT. ym_dout is ignored and poll_timeout is tied to 0.

Decomposition:
- Shared package jt10_bus_pkg holds:
  - the FSM state enum
  - the request struct {bank, reg, data}
  - constants for the port offsets and the busy bit index
- One sub-module: jt10_bus_fifo, a synchronous FIFO with registered full/empty and a level output.

Test Plan:
- One request (bank0, reg 0x28, data 0xF0): address strobe with addr=0, din=0x28; exactly 17 cen ticks later, data strobe with addr=1, din=0xF0; idle=1 after 83 more ticks.
- Bank-1 request (reg 0x10, data 0x55): strobes appear on addr=2 then addr=3.
- Push 17 requests with no pops: req_ready=0 at level 16 and the 17th is not accepted. All 16 are replayed in order; idle=1 only after the last DATA_WAIT.
- cen=1 every 4th clk: each strobe is low for exactly 4 clk; wait durations scale by 4.
- Assert rst_n=0 during DSTB: cs_n/wr_n go high in the same cycle; after release, level=0 and idle=1.
- With JT10_BUSY_POLL_EN: ym_dout[7]=1 for 3 reads then 0 → 4 read cycles, then IDLE. Busy stuck at 1 → poll_timeout=1 after exactly 255 reads.
